// File: rtl/rule110_readout_if.sv
// Valid/ready word stream carrying snapshot frames from rule110_readout to its consumer.
interface rule110_readout_if #(
  parameter int unsigned W = 32
);
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         out_ready;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/rule110_readout.sv
// Snapshot reader for the Rule 110 state bus: frames {generation header, CELLS/W data words}.
// Define POPCOUNT_EN to append a trailing word holding the snapshot's population count.
module rule110_readout #(
  parameter int unsigned CELLS = 512,
  parameter int unsigned W     = 32,
  parameter int unsigned GEN_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CELLS-1:0]  q_in,
  input  logic              load_obs,
  input  logic              snap_req,
  rule110_readout_if.master out_if,
  output logic              busy,
  output logic [7:0]        drop_cnt
);
  localparam int unsigned N    = CELLS / W;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  typedef enum logic [1:0] {StIdle, StHdr, StData, StPop} state_e;

  state_e           state_q, state_d;
  logic [CELLS-1:0] snap_q, snap_d;
  logic [GEN_W-1:0] gen_cnt_q, gen_cnt_d;
  logic [GEN_W-1:0] gen_snap_q, gen_snap_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic         valid, last, hs, accept, drop;
  logic [W-1:0] data, data_word;

  assign data_word = snap_q[idx_q*W +: W];

`ifdef POPCOUNT_EN
  localparam int unsigned PopW = $clog2(CELLS) + 1;
  logic [PopW-1:0] pop_q, pop_d, word_ones;

  always_comb begin
    word_ones = '0;
    for (int i = 0; i < W; i++) begin
      word_ones = word_ones + PopW'(data_word[i]);
    end
  end

  always_comb begin
    pop_d = pop_q;
    if (accept) begin
      pop_d = '0;
    end else if (hs && state_q == StData) begin
      pop_d = pop_q + word_ones;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_q <= '0;
    end else begin
      pop_q <= pop_d;
    end
  end
`endif

  // Output decode depends only on registered state, so data/last hold through stalls.
  always_comb begin
    valid = 1'b0;
    last  = 1'b0;
    data  = '0;
    unique case (state_q)
      StIdle: ;
      StHdr: begin
        valid = 1'b1;
        data  = W'(gen_snap_q);
      end
      StData: begin
        valid = 1'b1;
        data  = data_word;
`ifndef POPCOUNT_EN
        last  = (idx_q == LastIdx);
`endif
      end
      StPop: begin
`ifdef POPCOUNT_EN
        valid = 1'b1;
        last  = 1'b1;
        data  = W'(pop_q);
`endif
      end
    endcase
  end

  assign hs     = valid && out_if.out_ready;
  // A request landing on the final-word handshake starts the next frame with no idle gap.
  assign accept = snap_req && ((state_q == StIdle) || (hs && last));
  assign drop   = snap_req && !accept && (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: ;
      StHdr: begin
        if (hs) begin
          state_d = StData;
          idx_d   = '0;
        end
      end
      StData: begin
        if (hs) begin
          if (idx_q == LastIdx) begin
`ifdef POPCOUNT_EN
            state_d = StPop;
`else
            state_d = StIdle;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StPop: begin
`ifdef POPCOUNT_EN
        if (hs) begin
          state_d = StIdle;
        end
`else
        state_d = StIdle;
`endif
      end
    endcase
    if (accept) begin
      state_d = StHdr;
    end
  end

  always_comb begin
    gen_cnt_d  = load_obs ? '0 : ((&gen_cnt_q) ? gen_cnt_q : gen_cnt_q + 1'b1);
    snap_d     = accept ? q_in : snap_q;
    gen_snap_d = accept ? gen_cnt_q : gen_snap_q;
    drop_cnt_d = (drop && !(&drop_cnt_q)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      snap_q     <= '0;
      gen_cnt_q  <= '0;
      gen_snap_q <= '0;
      idx_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      gen_cnt_q  <= gen_cnt_d;
      gen_snap_q <= gen_snap_d;
      idx_q      <= idx_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign out_if.out_valid = valid;
  assign out_if.out_data  = data;
  assign out_if.out_last  = last;
  assign busy             = (state_q != StIdle);
  assign drop_cnt         = drop_cnt_q;

endmodule

// File: tb/tb_rule110_readout.sv
// Scoreboard bench for rule110_readout: a frame-level reference model queues expected words.
module tb_rule110_readout;
  localparam int unsigned CELLS = 512;
  localparam int unsigned W     = 32;
  localparam int unsigned GEN_W = 16;
  localparam int unsigned N     = CELLS / W;
`ifdef POPCOUNT_EN
  localparam int FL = N + 2;
`else
  localparam int FL = N + 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CELLS-1:0] q_in = '0;
  logic             load_obs = 1'b0;
  logic             snap_req = 1'b0;
  logic             busy;
  logic [7:0]       drop_cnt;

  rule110_readout_if #(.W(W)) out_if ();

  rule110_readout #(.CELLS(CELLS), .W(W), .GEN_W(GEN_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .q_in    (q_in),
    .load_obs(load_obs),
    .snap_req(snap_req),
    .out_if  (out_if.master),
    .busy    (busy),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [W:0]   exp_q[$];
  int           remaining = 0;
  int           gen_m = 0;
  int           drop_m = 0;
  int           wcount = 0;
  bit           stalled = 1'b0;
  logic [W-1:0] held = '0;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor first (what the DUT shows now), then the model for the coming edge.
  always @(negedge clk) begin
    bit hs;
    if (!rst_n) begin
      exp_q.delete();
      remaining = 0;
      gen_m     = 0;
      drop_m    = 0;
      wcount    = 0;
      stalled   = 1'b0;
    end else begin
      hs = out_if.out_valid && out_if.out_ready;
      if (stalled) begin
        check("stall_valid", out_if.out_valid, 1);
        check("stall_data", out_if.out_data, held);
      end
      if (out_if.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h expected no word", out_if.out_data);
        end else begin
          check("word", {out_if.out_last, out_if.out_data}, exp_q[0]);
          if (hs) begin
            void'(exp_q.pop_front());
            wcount++;
            if (out_if.out_last) begin
              check("frame_len", wcount, FL);
              wcount = 0;
            end
          end
        end
      end
      stalled = out_if.out_valid && !out_if.out_ready;
      held    = out_if.out_data;
      check("busy", busy, remaining > 0);
      check("drop_cnt", drop_cnt, drop_m);

      if (snap_req && (remaining == 0 || (hs && remaining == 1))) begin
        exp_q.push_back({1'b0, W'(gen_m)});
        for (int i = 0; i < N; i++) begin
          exp_q.push_back({(FL == N + 1) && (i == N - 1), q_in[i*W +: W]});
        end
`ifdef POPCOUNT_EN
        exp_q.push_back({1'b1, W'($countones(q_in))});
`endif
        remaining = FL;
      end else begin
        if (snap_req && remaining > 0 && drop_m < 255) drop_m++;
        if (hs) remaining--;
      end
      gen_m = load_obs ? 0 : ((gen_m < (1 << GEN_W) - 1) ? gen_m + 1 : gen_m);
    end
  end

  // rmode: 0 = ready low, 1 = ready high, 2 = random ready
  task automatic step(input bit snap, input bit load, input int rmode);
    @(posedge clk);
    #1;
    snap_req         = snap;
    load_obs         = load;
    out_if.out_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'(rmode);
  endtask

  task automatic drain(input int rmode, input int budget);
    int n = 0;
    step(0, 0, rmode);
    while ((busy || exp_q.size() != 0) && n < budget) begin
      step(0, 0, rmode);
      n++;
    end
    checks++;
    if (busy || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: busy=%0b pending=%0d required idle with none pending",
               busy, exp_q.size());
    end
    step(0, 0, 1);
  endtask

  task automatic rand_q();
    for (int i = 0; i < N; i++) q_in[i*W +: W] = $urandom;
  endtask

  initial begin
    bit found;
    out_if.out_ready = 1'b0;
    #2;
    check("rst_valid", out_if.out_valid, 0);
    check("rst_last", out_if.out_last, 0);
    check("rst_data", out_if.out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Generation tag after one load and five free-running edges.
    step(0, 1, 1);
    repeat (5) step(0, 0, 1);
    q_in = '0;
    q_in[0] = 1'b1;
    step(1, 0, 1);
    drain(1, 200);

    // Fixed pattern with random back-pressure.
    q_in = {16{32'hA5A5_0F0F}};
    step(1, 0, 2);
    drain(2, 500);

    // Requests during a stalled frame are dropped and the snapshot is kept.
    rand_q();
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    rand_q();
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    check("drop_one", drop_cnt, 1);
    repeat (300) begin
      step(1, 0, 0);
      rand_q();
    end
    step(0, 0, 0);
    step(0, 0, 0);
    check("drop_sat", drop_cnt, 8'hFF);
    drain(2, 500);

    // Request on the final-word handshake gives a back-to-back frame.
    rand_q();
    step(1, 0, 1);
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      step(0, 0, 1);
      if (out_if.out_valid && out_if.out_last) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL b2b_last_seen: got no final word expected one within 100 cycles");
    end
    rand_q();
    snap_req = 1'b1;
    step(0, 0, 1);
    check("b2b_valid", out_if.out_valid, 1);
    check("b2b_busy", busy, 1);
    drain(1, 200);

    // Extreme populations, then random frames with interleaved seed loads.
    q_in = '1;
    step(1, 0, 2);
    drain(2, 500);
    q_in = '0;
    step(1, 0, 1);
    drain(1, 200);
    repeat (4) begin
      rand_q();
      repeat ($urandom_range(0, 6)) step(0, $urandom_range(0, 3) == 0, 1);
      step(1, $urandom_range(0, 1), 2);
      drain(2, 500);
    end

    // Asynchronous reset mid-frame abandons the frame and clears the drop count.
    rand_q();
    step(1, 0, 2);
    repeat (6) step(0, 0, 2);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", out_if.out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_last", out_if.out_last, 0);
    check("midrst_drop", drop_cnt, 0);
    step(0, 0, 1);
    step(0, 0, 1);
    rst_n = 1'b1;
    rand_q();
    step(1, 0, 1);
    drain(1, 200);

    step(0, 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
